// File: rtl/fetch_execute_unit.sv
// fetch_execute_unit: accumulator-machine control stage.
// Fetches 16-bit instructions, decodes them, and sequences memory reads/writes.
// Drives a downstream combinational ALU and holds the PC, IR, MBR and accumulator.
module fetch_execute_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_operand1,
  output logic [15:0] alu_operand2,
  input  logic [15:0] alu_result,
  output logic [15:0] pc_out,
  output logic [15:0] acc_out,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMRD,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_HALT  = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_JUMP  = 4'h3,
    OP_JUMPZ = 4'h4,
    OP_ALUM  = 4'h5,
    OP_ALUI  = 4'h6
  } op_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] mbr;
  logic [15:0] ac;

  logic [3:0]  op;
  logic [15:0] addr12;
  logic [15:0] addr8;

  assign op     = ir[15:12];
  assign addr12 = {4'h0, ir[11:0]};
  assign addr8  = {8'h00, ir[7:0]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_next = S_FETCH;
    unique case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (op == OP_LOAD || op == OP_ALUM) begin
          state_next = S_MEMRD;
        end else if (op == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEMRD:  state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Architectural registers: PC, IR, MBR, accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_PC;
      ir  <= '0;
      mbr <= '0;
      ac  <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          ir <= mem_rdata;
          pc <= pc + 16'd1;
        end
        S_EXEC: begin
          case (op)
            OP_JUMP:  pc <= addr12;
            OP_JUMPZ: if (ac == '0) pc <= addr12;
            OP_ALUI:  ac <= alu_result;
            default:  ;
          endcase
        end
        S_MEMRD: mbr <= mem_rdata;
        S_WB: begin
          if (op == OP_LOAD) begin
            ac <= mbr;
          end else if (op == OP_ALUM) begin
            ac <= alu_result;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory, ALU and status drive
  always_comb begin
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = ac;
    alu_opcode   = ir[11:8];
    alu_operand1 = ac;
    alu_operand2 = (state == S_WB) ? mbr : addr8;
    halted       = (state == S_HALT);
    case (state)
      S_FETCH: mem_addr = pc;
      S_EXEC: begin
        case (op)
          OP_LOAD: mem_addr = addr12;
          OP_ALUM: mem_addr = addr8;
          OP_STORE: begin
            mem_addr = addr12;
            mem_we   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign pc_out  = pc;
  assign acc_out = ac;

endmodule

// File: tb/tb_fetch_execute_unit.sv
// Self-checking bench for fetch_execute_unit: shared MainMemory model,
// reference ALU, table-driven programs and a store scoreboard.
module tb_fetch_execute_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0 = 1'b1;
  logic reset1 = 1'b1;
  logic sel    = 1'b0;

  // Memory backdoor used only while the DUTs are held in reset
  logic        bd_clear = 1'b0;
  logic        bd_we    = 1'b0;
  logic [15:0] bd_addr  = '0;
  logic [15:0] bd_data  = '0;

  logic [15:0] mem [16384];
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        m_we;

  logic [15:0] d0_addr, d0_wdata, d0_op1, d0_op2, d0_res, d0_pc, d0_acc;
  logic [3:0]  d0_opc;
  logic        d0_we, d0_halted;
  logic [15:0] d1_addr, d1_wdata, d1_op1, d1_op2, d1_res, d1_pc, d1_acc;
  logic [3:0]  d1_opc;
  logic        d1_we, d1_halted;

  function automatic logic [15:0] alu_f(input logic [3:0] opc, input logic [15:0] a,
                                        input logic [15:0] b);
    case (opc)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      default: return b;
    endcase
  endfunction

  assign d0_res  = alu_f(d0_opc, d0_op1, d0_op2);
  assign d1_res  = alu_f(d1_opc, d1_op1, d1_op2);
  assign m_addr  = sel ? d1_addr : d0_addr;
  assign m_wdata = sel ? d1_wdata : d0_wdata;
  assign m_we    = sel ? d1_we : d0_we;

  // MainMemory: registered read, data_out held on write cycles, 16K words aliased
  always @(posedge clk) begin
    if (bd_clear) begin
      for (int i = 0; i < 16384; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_addr[13:0]] <= bd_data;
    end else if (m_we) begin
      mem[m_addr[13:0]] <= m_wdata;
    end
    if (!m_we) m_rdata <= mem[m_addr[13:0]];
  end

  fetch_execute_unit #(.RESET_PC(16'h0000)) u_dut0 (
    .clk(clk), .reset(reset0),
    .mem_addr(d0_addr), .mem_wdata(d0_wdata), .mem_we(d0_we), .mem_rdata(m_rdata),
    .alu_opcode(d0_opc), .alu_operand1(d0_op1), .alu_operand2(d0_op2),
    .alu_result(d0_res), .pc_out(d0_pc), .acc_out(d0_acc), .halted(d0_halted)
  );

  fetch_execute_unit #(.RESET_PC(16'hFFFF)) u_dut1 (
    .clk(clk), .reset(reset1),
    .mem_addr(d1_addr), .mem_wdata(d1_wdata), .mem_we(d1_we), .mem_rdata(m_rdata),
    .alu_opcode(d1_opc), .alu_operand1(d1_op1), .alu_operand2(d1_op2),
    .alu_result(d1_res), .pc_out(d1_pc), .acc_out(d1_acc), .halted(d1_halted)
  );

  typedef struct {
    logic [7:0][15:0] prog;
    logic [15:0]      a0, v0, a1, v1;
    logic [15:0]      exp_ac, exp_pc;
    int               exp_cycles;
    logic             st_valid;
    logic [15:0]      st_addr, st_data;
  } vec_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } st_t;

  st_t  sq[$];
  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(
    input logic [15:0] p0, p1, p2, p3, p4, p5, p6, p7,
    input logic [15:0] a0, v0, a1, v1, eac, epc,
    input int ecyc, input logic sv, input logic [15:0] sa, sd);
    vec_t v;
    v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
    v.prog[4] = p4; v.prog[5] = p5; v.prog[6] = p6; v.prog[7] = p7;
    v.a0 = a0; v.v0 = v0; v.a1 = a1; v.v1 = v1;
    v.exp_ac = eac; v.exp_pc = epc; v.exp_cycles = ecyc;
    v.st_valid = sv; v.st_addr = sa; v.st_data = sd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic mem_clear();
    bd_clear = 1'b1;
    @(posedge clk);
    #1 bd_clear = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   cyc;
    st_t  got;
    v = vecs[idx];
    reset0 = 1'b0;
    sel    = 1'b0;
    mem_clear();
    for (int i = 0; i < 8; i++) bd_write(16'(i), v.prog[i]);
    bd_write(v.a0, v.v0);
    bd_write(v.a1, v.v1);
    sq.delete();
    if (v.st_valid) sq.push_back('{a: v.st_addr, d: v.st_data});
    @(negedge clk);
    reset0 = 1'b1;
    cyc = 0;
    while (!d0_halted && cyc < 200) begin
      edges(1);
      cyc++;
      if (d0_we) begin
        if (sq.size() == 0) begin
          chk($sformatf("v%0d_unexpected_store", idx), {d0_addr, d0_wdata}, '0);
        end else begin
          got = sq.pop_front();
          chk($sformatf("v%0d_store_addr", idx), d0_addr, got.a);
          chk($sformatf("v%0d_store_data", idx), d0_wdata, got.d);
        end
      end
    end
    chk($sformatf("v%0d_halted", idx), d0_halted, 1);
    chk($sformatf("v%0d_cycles", idx), cyc, v.exp_cycles);
    chk($sformatf("v%0d_acc", idx), d0_acc, v.exp_ac);
    chk($sformatf("v%0d_pc", idx), d0_pc, v.exp_pc);
    chk($sformatf("v%0d_pending_stores", idx), sq.size(), 0);
    @(negedge clk);
    reset0 = 1'b0;
  endtask

  initial begin
    //            program words 0..7                                             data slot 0    data slot 1    ac       pc       cyc  store
    vecs[0] = mk(16'h1005, 16'h0000, 0, 0, 0, 0, 0, 0,                         16'h05, 16'h00AB, 16'h3F, 0, 16'h00AB, 16'h0002,  8, 0, 0, 0);
    vecs[1] = mk(16'h1020, 16'h5021, 16'h6102, 16'h0000, 0, 0, 0, 0,           16'h20, 16'h0007, 16'h21, 3, 16'h0008, 16'h0004, 16, 0, 0, 0);
    vecs[2] = mk(16'h1022, 16'h2030, 16'h1031, 16'h1030, 16'h0000, 0, 0, 0,    16'h22, 16'h1234, 16'h30, 16'h5555,
                 16'h1234, 16'h0005, 21, 1, 16'h0030, 16'h1234);
    vecs[3] = mk(16'h1023, 16'h4010, 16'h0000, 0, 0, 0, 0, 0,                  16'h10, 16'h0000, 16'h23, 0, 16'h0000, 16'h0011, 11, 0, 0, 0);
    vecs[4] = mk(16'h1024, 16'h4010, 16'h0000, 0, 0, 0, 0, 0,                  16'h24, 16'h0001, 16'h10, 16'h6001,
                 16'h0001, 16'h0003, 11, 0, 0, 0);
    vecs[5] = mk(16'h6005, 16'h7000, 16'h3006, 16'h0000, 16'h6FFF, 0, 16'h6203, 16'h0000,
                 16'h3F, 0, 16'h3E, 0, 16'h0001, 16'h0008, 15, 0, 0, 0);
    vecs[6] = mk(16'h6101, 16'h6001, 16'h4005, 16'h6007, 16'h0000, 16'h0000, 0, 0,
                 16'h3F, 0, 16'h3E, 0, 16'h0000, 16'h0006, 12, 0, 0, 0);

    // Create a real falling edge on both resets
    #1 reset0 = 1'b0;
    reset1 = 1'b0;
    #2;
    chk("rst_pc", d0_pc, 16'h0000);
    chk("rst_acc", d0_acc, 16'h0000);
    chk("rst_halted", d0_halted, 1'b0);
    chk("rst_we", d0_we, 1'b0);
    chk("rst_addr", d0_addr, 16'h0000);
    chk("rst_alu_opc", d0_opc, 4'h0);
    chk("rst_alu_op1", d0_op1, 16'h0000);
    chk("rst_alu_op2", d0_op2, 16'h0000);
    chk("rst1_pc", d1_pc, 16'hFFFF);
    chk("rst1_addr", d1_addr, 16'hFFFF);

    for (int i = 0; i < 7; i++) run_vec(i);

    // ALU path trace: AC 7 -> 10 -> 8, operand muxing in WB and ALUI EXEC
    mem_clear();
    bd_write(16'h0000, 16'h1020);
    bd_write(16'h0001, 16'h5021);
    bd_write(16'h0002, 16'h6102);
    bd_write(16'h0003, 16'h0000);
    bd_write(16'h0020, 16'h0007);
    bd_write(16'h0021, 16'h0003);
    @(negedge clk);
    reset0 = 1'b1;
    edges(5);
    chk("trace_acc_load", d0_acc, 16'h0007);
    edges(2);
    chk("trace_alum_exec_addr", d0_addr, 16'h0021);
    edges(2);
    chk("trace_wb_operand2", d0_op2, 16'h0003);
    edges(1);
    chk("trace_acc_alum", d0_acc, 16'h000A);
    edges(2);
    chk("trace_alui_opcode", d0_opc, 4'h1);
    chk("trace_alui_operand2", d0_op2, 16'h0002);
    edges(1);
    chk("trace_acc_alui", d0_acc, 16'h0008);
    @(negedge clk);
    reset0 = 1'b0;

    // Async reset while ALUM sits in MEMRD
    @(negedge clk);
    reset0 = 1'b1;
    edges(8);
    chk("abort_acc_before", d0_acc, 16'h0007);
    reset0 = 1'b0;
    #1;
    chk("abort_acc", d0_acc, 16'h0000);
    chk("abort_pc", d0_pc, 16'h0000);
    chk("abort_addr", d0_addr, 16'h0000);
    chk("abort_alu_opc", d0_opc, 4'h0);
    chk("abort_halted", d0_halted, 1'b0);
    @(negedge clk);
    reset0 = 1'b1;
    edges(5);
    chk("abort_restart_acc", d0_acc, 16'h0007);
    chk("abort_restart_pc", d0_pc, 16'h0001);
    @(negedge clk);
    reset0 = 1'b0;

    // PC wrap on the FFFF-reset instance
    sel = 1'b1;
    mem_clear();
    bd_write(16'h3FFF, 16'h7000);
    bd_write(16'h0000, 16'h0000);
    @(negedge clk);
    reset1 = 1'b1;
    chk("wrap_fetch_addr", d1_addr, 16'hFFFF);
    edges(2);
    chk("wrap_pc_after_decode", d1_pc, 16'h0000);
    edges(1);
    chk("wrap_next_fetch_addr", d1_addr, 16'h0000);
    edges(3);
    chk("wrap_halted", d1_halted, 1'b1);
    chk("wrap_final_pc", d1_pc, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_execute_unit.md
# fetch_execute_unit

Accumulator-machine control stage for the CPU. It fetches 16-bit instructions from `MainMemory`, decodes them, and sequences memory reads and writes. It drives the combinational `ALU`, sitting directly upstream of that block and feeding its opcode and operands. The unit holds the architectural PC, IR, MBR and accumulator internally.

## Interface
Parameters:
- `RESET_PC`, default `16'h0000`: PC value loaded on reset.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low; 0 resets immediately.
- `mem_addr` out 16: address to `MainMemory.addr`.
- `mem_wdata` out 16: write data to `MainMemory.data_in`.
- `mem_we` out 1: to `MainMemory.write_enable`.
- `mem_rdata` in 16: from `MainMemory.data_out`. Registered, valid the cycle after the address is presented with `mem_we`=0.
- `alu_opcode` out 4: to `ALU.opcode`.
- `alu_operand1` out 16: to `ALU.operand1`.
- `alu_operand2` out 16: to `ALU.operand2`.
- `alu_result` in 16: from `ALU.result`, combinational.
- `pc_out` out 16: current PC.
- `acc_out` out 16: current accumulator.
- `halted` out 1: 1 while in HALT state.

## Operation
Instruction format: `[15:12]` op. For memory and jump ops, `[11:0]` is addr, zero-extended to 16 bits. For ALU ops, `[11:8]` is the ALU opcode and `[7:0]` is addr8 or imm8, zero-extended.

Ops:
- 0 HALT
- 1 LOAD: AC←M[addr]
- 2 STORE: M[addr]←AC
- 3 JUMP: PC←addr
- 4 JUMPZ: PC←addr if AC==0
- 5 ALUM: AC←ALU(AC, M[addr8])
- 6 ALUI: AC←ALU(AC, imm8)
- 7–F: NOP

States are FETCH, DECODE, EXEC, MEMRD, WB, HALT. Reset state is FETCH.
- FETCH: `mem_addr`=PC, `mem_we`=0. Next state DECODE.
- DECODE: IR←`mem_rdata`; PC←PC+1 (16-bit wrap, FFFF→0000). Next state EXEC.
- EXEC: action depends on IR op.
  - LOAD/ALUM: `mem_addr`=addr. Next state MEMRD.
  - STORE: `mem_addr`=addr, `mem_wdata`=AC, `mem_we`=1. Next state FETCH.
  - JUMP/JUMPZ: update PC as defined. Next state FETCH.
  - ALUI: AC←`alu_result`. Next state FETCH.
  - NOP: next state FETCH.
  - HALT: next state HALT.
- MEMRD: MBR←`mem_rdata`. Next state WB.
- WB: LOAD sets AC←MBR; ALUM sets AC←`alu_result`. Next state FETCH.
- HALT: absorbing; only reset leaves it.

ALU drive (combinational, every cycle):
- `alu_opcode`=IR[11:8].
- `alu_operand1`=AC.
- `alu_operand2`=MBR in WB; otherwise {8'h00, IR[7:0]}.

Memory drive:
- `mem_we` is 1 only in EXEC of STORE.
- `mem_addr` is 0 in DECODE/MEMRD/WB/HALT; `mem_wdata`=AC always.

Arithmetic and width rules:
- AC takes `alu_result` unmodified, truncated to 16 bits by the ALU.
- Divide-by-zero result is whatever the ALU returns; the unit does not check.
- JUMPZ tests the AC value at EXEC.

## Timing
- Reset (`reset`=0, async) sets:
  - PC=`RESET_PC`, IR=MBR=AC=0, state FETCH.
  - `mem_we`=0, `mem_addr`=`RESET_PC`, `halted`=0.
  - `alu_opcode`=0, `alu_operand1`=0, `alu_operand2`=0.
- Reset mid-instruction aborts it. A STORE in EXEC is dropped if reset asserts before the edge.
- First FETCH occurs in the first cycle after `reset` deasserts.
- Cycles per instruction:
  - LOAD, ALUM: 5 (FETCH, DECODE, EXEC, MEMRD, WB).
  - STORE, JUMP, JUMPZ, ALUI, NOP: 3.
  - HALT: enters HALT 3 cycles after its FETCH.
- Memory read latency: exactly 1 cycle (address in cycle N, data sampled in N+1).
- Write/read conflict: `MainMemory` does not update `data_out` on write cycles. The unit never depends on `mem_rdata` in the cycle following a STORE, because the next state is FETCH.
- Address wrap: PC at FFFF fetches FFFF, then the next FETCH is at 0000. Fetches from 4000–FFFF alias per memory behaviour and are not checked.
- Self-jump: JUMP to the current instruction loops forever, with the PC oscillating between addr+1 and addr.

## Test plan
- Reset and single LOAD:
  - Stimulus: M[0]=`1005`, M[5]=`00AB`, M[1]=`0000`.
  - Required: `acc_out`=`00AB` after cycle 5; `halted`=1 at cycle 8; PC=2.
- ALU paths:
  - Stimulus: LOAD 0x20 (M[20]=7), then `5021` (ALUM add, M[21]=3), then `6102` (ALUI sub 2).
  - Required: AC sequence 7→10→8; `alu_opcode`=1 during the ALUI EXEC.
- STORE and memory-write handshake:
  - Stimulus: AC=`1234`, then `2030`.
  - Required: `mem_we`=1 for exactly one cycle with `mem_addr`=`0030`, `mem_wdata`=`1234`; a later LOAD 0x30 returns `1234`.
- JUMPZ taken and not taken:
  - Stimulus: AC=0 with `4010` → PC=`0010`. AC=1 with `4010` → PC=next sequential.
  - Required: 3 cycles each.
- Async reset mid-ALUM:
  - Stimulus: assert `reset`=0 in MEMRD.
  - Required: immediate return to reset values; AC=0; fetch restarts at `RESET_PC` after release.
- PC wrap and NOP:
  - Stimulus: `RESET_PC`=`FFFF`, M[FFFF aliased]=`7000`.
  - Required: PC goes FFFF→0000 after DECODE; next FETCH has `mem_addr`=0000.
